// File: rtl/data_downsampler.sv
// Ping-pong frame buffer: bursty I/Q frames are captured, then replayed at one sample per RATE clocks.
// Define DATA_DOWNSAMPLER_DROP_EN to keep in_ready high and drop/count samples that arrive while both banks are full.
module data_downsampler #(
  parameter int DATA_WIDTH   = 12,
  parameter int BUFFER_DEPTH = 2048,
  parameter int RATE         = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] in_data_i,
  input  logic [DATA_WIDTH-1:0] in_data_q,
  input  logic                  in_valid,
  input  logic                  in_eop,
  output logic                  in_ready,
  output logic [DATA_WIDTH-1:0] out_data_i,
  output logic [DATA_WIDTH-1:0] out_data_q,
  output logic                  out_valid,
  output logic                  out_sop,
  output logic                  out_eop,
  output logic [15:0]           ovf_count
);
  localparam int AW  = $clog2(BUFFER_DEPTH);
  localparam int PW  = $clog2(RATE);
  localparam int SW  = $clog2(RATE + 1);
  localparam int GAP = (RATE > 3) ? RATE - 3 : 0;
`ifdef DATA_DOWNSAMPLER_DROP_EN
  localparam bit DROP = 1'b1;
`else
  localparam bit DROP = 1'b0;
`endif

  typedef enum logic {FILL, WAIT} wstate_t;
  typedef enum logic {IDLE, PACE} rstate_t;

  wstate_t                 wstate;
  rstate_t                 rstate;
  logic [2*DATA_WIDTH-1:0] mem [2*BUFFER_DEPTH];
  logic                    wbank, rbank;
  logic [AW-1:0]           waddr, raddr;
  logic [AW-1:0]           last [2];
  logic [1:0]              full;
  logic [PW-1:0]           ph;
  logic [SW-1:0]           since;
  logic                    issued;
  logic                    accept, drop, close, free, other_busy, rd_en, rd_last;
  logic                    vld_p0, sop_p0, eop_p0;
  logic [2*DATA_WIDTH-1:0] rdata_p0;

  assign in_ready   = ~rst & (DROP | (wstate == FILL));
  assign accept     = in_valid & in_ready & (wstate == FILL);
  assign drop       = DROP & in_valid & in_ready & (wstate == WAIT);
  assign close      = accept & (in_eop | (&waddr));
  assign free       = out_valid & out_eop;
  // A bank being freed this very cycle counts as available, so filling never loses a cycle.
  assign other_busy = full[~wbank] & ~(free & (rbank == ~wbank));
  assign rd_en      = (rstate == PACE) & (ph == '0) & ~issued;
  assign rd_last    = (raddr == last[rbank]);

  // Write side: bank selection, frame close and overflow accounting.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wstate    <= FILL;
      wbank     <= 1'b0;
      waddr     <= '0;
      full      <= '0;
      last[0]   <= '0;
      last[1]   <= '0;
      ovf_count <= '0;
    end else begin
      full <= (full | ({1'b0, close} << wbank)) & ~({1'b0, free} << rbank);
      if (drop && ovf_count != 16'hFFFF)
        ovf_count <= ovf_count + 16'd1;
      case (wstate)
        FILL: begin
          if (accept) begin
            if (close) begin
              last[wbank] <= waddr;
              wbank       <= ~wbank;
              waddr       <= '0;
              if (other_busy)
                wstate <= WAIT;
            end else begin
              waddr <= waddr + 1'b1;
            end
          end
        end
        WAIT: begin
          if (~full[wbank] | (free & (rbank == wbank)))
            wstate <= FILL;
        end
        default: wstate <= FILL;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (accept)
      mem[{wbank, waddr}] <= {in_data_q, in_data_i};
    rdata_p0 <= mem[{rbank, raddr}];
  end

  // Read side: 'since' keeps inter-frame strobes at least RATE apart given the 3-cycle IDLE-to-output path.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rstate <= IDLE;
      rbank  <= 1'b0;
      raddr  <= '0;
      ph     <= '0;
      issued <= 1'b0;
      since  <= SW'(RATE);
    end else begin
      if (out_valid)
        since <= SW'(1);
      else if (since != SW'(RATE))
        since <= since + 1'b1;
      case (rstate)
        IDLE: begin
          if (full[rbank] && since >= SW'(GAP)) begin
            rstate <= PACE;
            raddr  <= '0;
            ph     <= '0;
            issued <= 1'b0;
          end
        end
        PACE: begin
          ph <= (ph == PW'(RATE - 1)) ? '0 : ph + 1'b1;
          if (rd_en) begin
            raddr <= raddr + 1'b1;
            if (rd_last)
              issued <= 1'b1;
          end
          if (free) begin
            rstate <= IDLE;
            rbank  <= ~rbank;
          end
        end
        default: rstate <= IDLE;
      endcase
    end
  end

  // p0: read address issued, BRAM data registered; final stage: output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_p0     <= 1'b0;
      sop_p0     <= 1'b0;
      eop_p0     <= 1'b0;
      out_valid  <= 1'b0;
      out_sop    <= 1'b0;
      out_eop    <= 1'b0;
      out_data_i <= '0;
      out_data_q <= '0;
    end else begin
      vld_p0     <= rd_en;
      sop_p0     <= rd_en & (raddr == '0);
      eop_p0     <= rd_en & rd_last;
      out_valid  <= vld_p0;
      out_sop    <= vld_p0 & sop_p0;
      out_eop    <= vld_p0 & eop_p0;
      out_data_i <= vld_p0 ? rdata_p0[DATA_WIDTH-1:0] : '0;
      out_data_q <= vld_p0 ? rdata_p0[2*DATA_WIDTH-1:DATA_WIDTH] : '0;
    end
  end
endmodule

// File: tb/tb_data_downsampler.sv
// Scoreboard bench for data_downsampler (BUFFER_DEPTH=8, RATE=4, DATA_WIDTH=12).
module tb_data_downsampler;
  localparam int DW    = 12;
  localparam int DEPTH = 8;
  localparam int RATE  = 4;
`ifdef DATA_DOWNSAMPLER_DROP_EN
  localparam bit DROP = 1'b1;
`else
  localparam bit DROP = 1'b0;
`endif

  typedef struct packed {
    logic [DW-1:0] q;
    logic [DW-1:0] i;
    logic          sop;
    logic          eop;
  } samp_t;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [DW-1:0] in_data_i = '0;
  logic [DW-1:0] in_data_q = '0;
  logic          in_valid = 1'b0;
  logic          in_eop = 1'b0;
  logic          in_ready;
  logic [DW-1:0] out_data_i, out_data_q;
  logic          out_valid, out_sop, out_eop;
  logic [15:0]   ovf_count;

  int            total = 0;
  int            bad = 0;
  int            cyc = 0;
  int            fcnt = 0;
  int            acc_total = 0;
  int            stall_at = -1;
  int            acc_cyc = 0;
  int            last_ov_cyc = 0;
  samp_t         sb[$];

  data_downsampler #(.DATA_WIDTH(DW), .BUFFER_DEPTH(DEPTH), .RATE(RATE)) dut (
    .clk(clk), .rst(rst),
    .in_data_i(in_data_i), .in_data_q(in_data_q),
    .in_valid(in_valid), .in_eop(in_eop), .in_ready(in_ready),
    .out_data_i(out_data_i), .out_data_q(out_data_q),
    .out_valid(out_valid), .out_sop(out_sop), .out_eop(out_eop),
    .ovf_count(ovf_count)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic monitor();
    samp_t got, exp;
    int    prev_cyc = 0;
    bit    have_prev = 0;
    bit    prev_eop = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        have_prev = 0;
        chk("rst_outputs", {out_valid, out_sop, out_eop, out_data_i, out_data_q, ovf_count}, 0);
      end else if (out_valid) begin
        got = {out_data_q, out_data_i, out_sop, out_eop};
        chk("sb_nonempty", sb.size() > 0, 1);
        if (sb.size() > 0) begin
          exp = sb.pop_front();
          chk("sample", got, exp);
        end
        if (have_prev) begin
          if (prev_eop) chk("frame_gap_ok", (cyc - prev_cyc) >= RATE, 1);
          else          chk("pace_gap", cyc - prev_cyc, RATE);
        end
        have_prev   = 1;
        prev_eop    = out_eop;
        prev_cyc    = cyc;
        last_ov_cyc = cyc;
      end else begin
        chk("idle_zero", {out_sop, out_eop, out_data_i, out_data_q}, 0);
      end
    end
  endtask

  task automatic send(input logic [DW-1:0] i, input logic [DW-1:0] q, input logic eop,
                      input bit expect_out);
    int    w = 0;
    samp_t s;
    @(negedge clk);
    in_valid  = 1'b1;
    in_data_i = i;
    in_data_q = q;
    in_eop    = eop;
    while (!in_ready && w < 300) begin
      if (stall_at < 0) stall_at = acc_total;
      @(negedge clk);
      w++;
    end
    if (!in_ready) begin
      chk("ready_timeout", in_ready, 1);
    end else begin
      acc_cyc = cyc + 1;
      acc_total++;
      if (expect_out) begin
        s.q   = q;
        s.i   = i;
        s.sop = (fcnt == 0);
        s.eop = eop || (fcnt == DEPTH - 1);
        sb.push_back(s);
        fcnt  = s.eop ? 0 : fcnt + 1;
      end
    end
  endtask

  task automatic idle();
    @(negedge clk);
    in_valid = 1'b0;
    in_eop   = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst      = 1'b1;
    in_valid = 1'b0;
    in_eop   = 1'b0;
    sb.delete();
    fcnt      = 0;
    acc_total = 0;
    stall_at  = -1;
    repeat (3) @(negedge clk);
    chk("rst_ready", in_ready, 0);
    chk("rst_ovf", ovf_count, 0);
    rst = 1'b0;
    #1;
    chk("release_ready", in_ready, 1);
  endtask

  task automatic drain();
    int w = 0;
    idle();
    while (sb.size() != 0 && w < 1000) begin
      @(negedge clk);
      w++;
    end
    chk("drain_empty", sb.size(), 0);
    repeat (3 * RATE) @(negedge clk);
  endtask

  task automatic main_seq();
    // Full-depth frame closes on the 8th sample.
    do_reset();
    for (int k = 0; k < 8; k++) send(DW'(k + 1), DW'(16 + k), 1'b0, 1'b1);
    drain();

    // Three short frames reuse both banks in turn.
    do_reset();
    for (int f = 0; f < 3; f++)
      for (int k = 0; k < 3; k++)
        send(DW'(12'h100 + 16 * f + k), DW'(12'h200 + 16 * f + k), k == 2, 1'b1);
    drain();

    // Single-sample frame; output appears 3 edges after the accepting edge.
    do_reset();
    send(12'hABC, 12'h123, 1'b1, 1'b1);
    drain();
    chk("first_latency", last_ov_cyc - acc_cyc, 3);

    // 24 back-to-back samples: stall (or drop) once both banks hold frames.
    do_reset();
    for (int k = 0; k < 24; k++)
      send(DW'(12'h300 + k), DW'(12'h400 + k), 1'b0, !DROP || k < 16);
    drain();
`ifdef DATA_DOWNSAMPLER_DROP_EN
    chk("ovf_drops", ovf_count, 8);
`else
    chk("stall_after", stall_at, 16);
    chk("ovf_zero", ovf_count, 0);
`endif

    // Reset mid-frame, then a fresh frame.
    do_reset();
    for (int k = 0; k < 5; k++) send(DW'(12'h500 + k), DW'(12'h600 + k), 1'b0, 1'b1);
    do_reset();
    for (int k = 0; k < 8; k++) send(DW'(12'h700 + k), DW'(12'h710 + k), 1'b0, 1'b1);
    drain();
  endtask

  initial begin
    fork
      monitor();
      main_seq();
    join_any
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/data_downsampler.md
DATA_DOWNSAMPLER -- requirements
Module: data_downsampler

Interface
REQ-001 Parameter DATA_WIDTH, default 12: width of each I and Q sample.
REQ-002 Parameter BUFFER_DEPTH, default 2048: maximum frame length in samples; power of two, at least 4.
REQ-003 Parameter RATE, default 4: output pacing in clk cycles per sample; at least 2.
REQ-004 clk  in  1  single clock for all logic.
REQ-005 rst  in  1  reset, asynchronous, active-high.
REQ-006 in_data_i / in_data_q  in  DATA_WIDTH each  burst input sample.
REQ-007 in_valid  in  1  input sample strobe; a sample is accepted on a cycle with in_valid=1 and in_ready=1.
REQ-008 in_eop  in  1  marks the last sample of an input frame; qualified by in_valid.
REQ-009 in_ready  out  1  input can accept a sample.
REQ-010 out_data_i / out_data_q  out  DATA_WIDTH each  paced output sample.
REQ-011 out_valid  out  1  one-cycle strobe per output sample.
REQ-012 out_sop / out_eop  out  1 each  first and last sample of an output frame; qualified by out_valid.
REQ-013 ovf_count  out  16  count of dropped input samples; saturates at 0xFFFF.

Function
REQ-014 Storage: two banks (ping-pong) of BUFFER_DEPTH x 2*DATA_WIDTH; packing {q,i}.
REQ-015 Write FSM states: FILL, WAIT. FILL writes accepted samples at incrementing addresses of the current write bank.
REQ-016 A bank closes on an accepted in_eop sample, or on the BUFFER_DEPTH-th accepted sample, whichever comes first.
REQ-017 On close, the bank's length (1..BUFFER_DEPTH) is latched, the bank is marked full, and writing switches to the other bank with address 0.
REQ-018 If the other bank is still full, the write FSM enters WAIT and stays there until that bank is freed.
REQ-019 Read FSM states: IDLE, PACE. From IDLE it enters PACE when the oldest full bank exists, with banks served in close order.
REQ-020 In PACE, out_valid pulses exactly once every RATE cycles.
REQ-021 The first out_valid of a frame occurs 2 cycles after PACE entry, allowing for the registered BRAM read.
REQ-022 Samples are emitted in write order.
REQ-023 out_sop is 1 with the first sample of a frame; out_eop is 1 with the sample at index length-1; both are 1 for a 1-sample frame.
REQ-024 On the out_eop cycle the bank is freed, and the read FSM returns to IDLE.
REQ-025 Consecutive frames are separated by at least RATE cycles between out_valid strobes.
REQ-026 out_data_i and out_data_q are 0 whenever out_valid=0.
REQ-027 Same-cycle free and close: a bank freed in the same cycle as the other bank closes allows FILL to continue with no lost cycle.
REQ-028 A simultaneous close and free of the same bank cannot occur and needs no handling.
REQ-029 in_eop with in_valid=0 is ignored.

Reset
REQ-030 While rst=1, all outputs are 0, except in_ready, which is 0 during reset and 1 on the first cycle after release.
REQ-031 Reset empties both banks, selects bank 0 for write and read, clears ovf_count, and puts both FSMs in FILL/IDLE.
REQ-032 Reset asserted mid-frame discards the partial frame; no out_eop is produced for it.

Configuration
REQ-033 Macro DATA_DOWNSAMPLER_DROP_EN selects the overflow behaviour.
REQ-034 Without DATA_DOWNSAMPLER_DROP_EN: in_ready=0 in WAIT, otherwise 1, and ovf_count stays 0.
REQ-035 With DATA_DOWNSAMPLER_DROP_EN: in_ready is constantly 1.
REQ-036 With DATA_DOWNSAMPLER_DROP_EN, each in_valid cycle in WAIT discards the sample and increments ovf_count.
REQ-037 With DATA_DOWNSAMPLER_DROP_EN, a dropped in_eop still ends the dropped frame, so the next accepted sample starts a new frame.

Verification (BUFFER_DEPTH=8, RATE=4, DATA_WIDTH=12)
REQ-038 8 back-to-back samples i=1..8, q=0x10..0x17, no eop -> 8 out_valid strobes 4 cycles apart with data in order; sop on i=1, eop on i=8.
REQ-039 3 samples with in_eop on the 3rd -> 3 output samples; out_eop on the 3rd; the bank is then reused.
REQ-040 Single sample with in_eop -> one out_valid with out_sop=out_eop=1.
REQ-041 24 back-to-back samples, no macro -> in_ready drops after sample 16 until the first bank frees; all 24 are output in order; ovf_count=0.
REQ-042 Same stimulus with DATA_DOWNSAMPLER_DROP_EN -> samples arriving in WAIT are dropped; ovf_count equals the number of drops; output frames are intact.
REQ-043 rst pulsed after 5 of 8 samples, then a fresh 8-sample frame -> no output from the partial frame; the new frame is output complete with sop/eop correct.
